// File: rtl/alu_bist_pkg.sv
// Shared constants and types for the ALU BIST response analyzer.
// Holds the MISR polynomial and seed, the FSM state type and the flag bit positions.
package alu_bist_pkg;

    // x^64 + x^4 + x^3 + x + 1
    localparam logic [63:0] MISR_POLY = 64'h0000_0000_0000_001B;
    localparam logic [63:0] SEED      = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StCheck   = 2'd2,
        StDone    = 2'd3
    } bist_state_e;

    localparam int unsigned FlagCarry    = 6;
    localparam int unsigned FlagOverflow = 5;
    localparam int unsigned FlagZero     = 4;
    localparam int unsigned FlagNegative = 3;
    localparam int unsigned FlagParity   = 2;
    localparam int unsigned FlagModulo   = 1;
    localparam int unsigned FlagSign     = 0;

endpackage

// File: rtl/alu_misr.sv
// Multiple-input signature register: shift-left Galois LFSR with a per-cycle parallel fold.
// Reset and load_seed both return the register to the seed; load_seed wins over en.
module alu_misr
    import alu_bist_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter logic [N-1:0] Poly = N'(MISR_POLY),
    parameter logic [N-1:0] Seed = N'(SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_seed,
    input  logic         en,
    input  logic [N-1:0] fold,
    output logic [N-1:0] sig
);

    logic [N-1:0] sig_d, sig_q;

    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = Seed;
        end else if (en) begin
            sig_d = {sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? Poly : '0) ^ fold;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= Seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/alu_bist_response_analyzer.sv
// BIST response collector for the 64-bit ALU: compresses accepted result beats into a MISR,
// counts vectors and flag events, and compares the final signature against a golden value.
module alu_bist_response_analyzer
    import alu_bist_pkg::*;
#(
    parameter int unsigned N       = 64,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned NUM_OPS = 35,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned EV_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] expected_count,
    input  logic [N-1:0]     golden_sig,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [N-1:0]     result,
    input  logic [N-1:0]     upper_result,
    input  logic [6:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     signature,
    output logic [CNT_W-1:0] vec_count,
    output logic [EV_W-1:0]  carry_count,
    output logic [EV_W-1:0]  overflow_count,
    output logic [EV_W-1:0]  zero_count,
    output logic             err_sel
);

    bist_state_e      state_d, state_q;
    logic [CNT_W-1:0] vec_d, vec_q;
    logic [CNT_W-1:0] exp_d, exp_q;
    logic [EV_W-1:0]  carry_d, carry_q;
    logic [EV_W-1:0]  ovf_d, ovf_q;
    logic [EV_W-1:0]  zero_d, zero_q;
    logic             err_d, err_q;
    logic             pass_d, pass_q;

    logic             run_start;
    logic             accept;
    logic             last_beat;
    logic [N-1:0]     fold;

    // start only takes effect from IDLE or DONE; it is ignored while a run is in flight
    assign run_start = start && ((state_q == StIdle) || (state_q == StDone));
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && ((vec_q + CNT_W'(1)) == exp_q);

    assign fold = result
                ^ {upper_result[N-2:0], upper_result[N-1]}
                ^ N'({in_sel, flags});

    alu_misr #(
        .N (N)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (run_start),
        .en        (accept),
        .fold      (fold),
        .sig       (signature)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = (expected_count == '0) ? StCheck : StCollect;
                end
            end
            StCollect: begin
                if (last_beat) begin
                    state_d = StCheck;
                end
            end
            StCheck: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StCollect: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StCheck: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        vec_d   = vec_q;
        exp_d   = exp_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        err_d   = err_q;
        pass_d  = pass_q;
        if (run_start) begin
            vec_d   = '0;
            exp_d   = expected_count;
            carry_d = '0;
            ovf_d   = '0;
            zero_d  = '0;
            err_d   = 1'b0;
            pass_d  = 1'b0;
        end else if (accept) begin
            vec_d = vec_q + CNT_W'(1);
            if (flags[FlagCarry] && (carry_q != '1)) begin
                carry_d = carry_q + EV_W'(1);
            end
            if (flags[FlagOverflow] && (ovf_q != '1)) begin
                ovf_d = ovf_q + EV_W'(1);
            end
            if (flags[FlagZero] && (zero_q != '1)) begin
                zero_d = zero_q + EV_W'(1);
            end
            if (32'(in_sel) >= NUM_OPS) begin
                err_d = 1'b1;
            end
        end else if (state_q == StCheck) begin
            pass_d = (signature == golden_sig) && !err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q   <= '0;
            exp_q   <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            zero_q  <= '0;
            err_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_count      = vec_q;
    assign carry_count    = carry_q;
    assign overflow_count = ovf_q;
    assign zero_count     = zero_q;
    assign err_sel        = err_q;
    assign pass           = pass_q;

endmodule
